// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: per-channel FSM encoding and default timing.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_DB_RELEASE = 2'd3
  } db_state_e;

  localparam int unsigned CNT_MAX_20MS_12M = 240000;

endpackage

// File: rtl/key_debounce_ch.sv
// Single-key conditioner: 2-flop synchroniser, debounce FSM with stability counter,
// registered level and press/release pulses.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_20MS_12M,
  parameter int unsigned CNT_W   = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_state,
  output logic key_press,
  output logic key_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             sync1;
  logic             ks;
  db_state_e        state;
  db_state_e        state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             press_nx;
  logic             release_nx;

  // Synchroniser resets to released; outputs follow the next state so they are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 1'b1;
      ks          <= 1'b1;
      state       <= ST_IDLE;
      cnt         <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      sync1       <= key_n;
      ks          <= sync1;
      state       <= state_nx;
      cnt         <= cnt_nx;
      key_state   <= (state_nx == ST_PRESSED) || (state_nx == ST_DB_RELEASE);
      key_press   <= press_nx;
      key_release <= release_nx;
    end
  end

  // Next-state and counter; any bounce during a debounce window restarts from the stable state.
  always_comb begin
    state_nx   = state;
    cnt_nx     = '0;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!ks) state_nx = ST_DB_PRESS;
      end
      ST_DB_PRESS: begin
        if (ks) begin
          state_nx = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nx = ST_PRESSED;
          press_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (ks) state_nx = ST_DB_RELEASE;
      end
      ST_DB_RELEASE: begin
        if (!ks) begin
          state_nx = ST_PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nx   = ST_IDLE;
          release_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/key_debounce.sv
// Multi-channel push-button conditioner: one independent debounce channel per key.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned KEY_NUM = 2,
  parameter int unsigned CNT_MAX = CNT_MAX_20MS_12M,
  parameter int unsigned CNT_W   = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_n,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release
);

  for (genvar i = 0; i < int'(KEY_NUM); i++) begin : g_ch
    key_debounce_ch #(
      .CNT_MAX (CNT_MAX),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_n       (key_n[i]),
      .key_state   (key_state[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce (CNT_MAX=8): directed scenarios plus random key activity.
module tb_key_debounce;

  localparam int KN   = 2;
  localparam int CMAX = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [KN-1:0] key_n = '1;
  logic [KN-1:0] key_state;
  logic [KN-1:0] key_press;
  logic [KN-1:0] key_release;

  key_debounce #(.KEY_NUM(KN), .CNT_MAX(CMAX), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n       (key_n),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  // Reference model: raw keys delayed two samples; a level is accepted once the
  // opposite level has been seen on CMAX+1 consecutive samples.
  logic [KN-1:0] d1, d2, m_acc, m_press, m_rel;
  int            run [KN];

  // Per-tick observations for directed timing checks.
  int n_tick;
  int press0_cnt, press0_at, rel0_cnt, rel0_at, both_cnt;

  task automatic model_reset();
    d1 = '1; d2 = '1; m_acc = '0; m_press = '0; m_rel = '0;
    for (int c = 0; c < KN; c++) run[c] = 0;
  endtask

  task automatic model_edge(input logic [KN-1:0] k);
    for (int c = 0; c < KN; c++) begin
      logic want;
      want = ~d2[c];
      m_press[c] = 1'b0;
      m_rel[c]   = 1'b0;
      if (want != m_acc[c]) run[c]++;
      else run[c] = 0;
      if (run[c] == CMAX + 1) begin
        m_acc[c] = want;
        run[c]   = 0;
        if (want) m_press[c] = 1'b1;
        else      m_rel[c]   = 1'b1;
      end
    end
    d2 = d1;
    d1 = k;
  endtask

  task automatic chk(input string tag, input logic [KN-1:0] obs, input logic [KN-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_state"},   key_state,   m_acc);
    chk({tag, "_press"},   key_press,   m_press);
    chk({tag, "_release"}, key_release, m_rel);
  endtask

  task automatic clear_obs();
    n_tick = 0; press0_cnt = 0; press0_at = -1; rel0_cnt = 0; rel0_at = -1; both_cnt = 0;
  endtask

  task automatic tick(input logic [KN-1:0] k, input string tag);
    key_n = k;
    @(posedge clk);
    model_edge(k);
    #1;
    check_outs(tag);
    if (key_press[0])   begin press0_cnt++; if (press0_at < 0) press0_at = n_tick; end
    if (key_release[0]) begin rel0_cnt++;   if (rel0_at < 0)   rel0_at   = n_tick; end
    if (key_press === 2'b11) both_cnt++;
    n_tick++;
  endtask

  initial begin
    int bounce_start;
    model_reset();
    clear_obs();

    #2;
    check_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 50; i++) tick(2'b11, "idle");
    chk_int("idle_no_press", press0_cnt, 0);

    clear_obs();
    for (int i = 0; i < 16; i++) tick(2'b10, "press0");
    chk_int("press0_count", press0_cnt, 1);
    chk_int("press0_latency", press0_at, CMAX + 2);
    chk("press0_level", key_state, 2'b01);

    clear_obs();
    for (int i = 0; i < 16; i++) tick(2'b11, "release0");
    chk_int("release0_count", rel0_cnt, 1);
    chk_int("release0_latency", rel0_at, CMAX + 2);
    chk("release0_level", key_state, 2'b00);

    clear_obs();
    for (int i = 0; i < 5; i++) tick(2'b10, "bounce");
    tick(2'b11, "bounce");
    for (int i = 0; i < 5; i++) tick(2'b10, "bounce");
    tick(2'b11, "bounce");
    bounce_start = n_tick;
    for (int i = 0; i < 16; i++) tick(2'b10, "bounce_hold");
    chk_int("bounce_count", press0_cnt, 1);
    chk_int("bounce_latency", press0_at - bounce_start, CMAX + 2);
    for (int i = 0; i < 16; i++) tick(2'b11, "bounce_rel");

    clear_obs();
    for (int i = 0; i < 16; i++) tick(2'b00, "both");
    chk_int("both_same_cycle", both_cnt, 1);
    chk("both_level", key_state, 2'b11);
    for (int i = 0; i < 16; i++) tick(2'b11, "both_rel");

    // Key 0 low for 8 edges leaves the channel mid-debounce (count 5).
    for (int i = 0; i < 8; i++) tick(2'b10, "pre_rst");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    for (int i = 0; i < 16; i++) tick(2'b10, "post_rst");
    chk_int("post_rst_count", press0_cnt, 1);
    chk_int("post_rst_latency", press0_at, CMAX + 2);
    for (int i = 0; i < 16; i++) tick(2'b11, "post_rst_rel");

    // Random holds of 1..14 cycles mix short glitches with accepted changes.
    for (int s = 0; s < 80; s++) begin
      logic [KN-1:0] k;
      int            len;
      k   = KN'($urandom);
      len = int'($urandom_range(1, 14));
      for (int i = 0; i < len; i++) tick(k, "random");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
